btn_conditioner: RTL

- Parametrised N-channel input conditioner for the pong top level. Replaces the direct use of raw ui_in button bits (p1/p2 up/down, serve, pause).
- Per channel: synchronises the asynchronous pin, debounces it, and produces a clean level, one-cycle press/release pulses, and an auto-repeat "step" pulse stream.
- Paddle logic consumes step pulses rather than raw levels, giving frame-rate-independent paddle motion.

---
 rtl/btn_conditioner_pkg.sv | 27 ++
 rtl/btn_conditioner_if.sv | 14 +
 rtl/btn_chan.sv | 126 ++++++++++++
 rtl/btn_conditioner.sv | 33 +++
 4 files changed

// File: rtl/btn_conditioner_pkg.sv
// Shared types and constants for the button conditioner.
package btn_conditioner_pkg;

  // Per-channel auto-repeat state.
  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StRepeat,
    StHold
  } btn_rep_state_t;

  // Default timings for a 25 MHz clock.
  localparam int unsigned DEBOUNCE_10MS = 250000;
  localparam int unsigned REPEAT_250MS  = 6250000;
  localparam int unsigned REPEAT_50MS   = 1250000;

  // Channel assignment on the pong top level.
  localparam int unsigned P1_UP = 0;
  localparam int unsigned P1_DN = 1;
  localparam int unsigned P2_UP = 2;
  localparam int unsigned P2_DN = 3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button pins in, conditioned levels and pulses out.
// The release pulse is carried as 'rel' because 'release' is a reserved word.
interface btn_conditioner_if #(
  parameter int unsigned N_CH = 4
);
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] rel;
  logic [N_CH-1:0] step;

  modport master (output btn_in, input level, input press, input rel, input step);
  modport slave  (input btn_in, output level, output press, output rel, output step);
endinterface

// File: rtl/btn_chan.sv
// Single button channel: synchroniser, debouncer and auto-repeat step generator.
module btn_chan
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int unsigned REPEAT_DELAY    = REPEAT_250MS,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_50MS
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic press,
  output logic rel,
  output logic step
);

  localparam int unsigned DebW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RepW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [DebW-1:0] DebLast   = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RepW-1:0] DelayLast = RepW'(REPEAT_DELAY - 1);
  // Never reached when auto-repeat is disabled; kept in range to avoid wrap.
  localparam logic [RepW-1:0] PeriodLast =
      RepW'((REPEAT_PERIOD == 0) ? 0 : REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic [DebW-1:0]        deb_cnt_q;
  logic                   level_q, press_q, rel_q, step_q;
  logic                   toggle, rise, fall;
  btn_rep_state_t         state_q;
  logic [RepW-1:0]        rep_cnt_q;

  // Shift the asynchronous pin through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Accept a change once the synced input has disagreed for DEBOUNCE_CYCLES evaluations.
  always_comb begin
    toggle = (sync_s != level_q) && (deb_cnt_q == DebLast);
    rise   = toggle && !level_q;
    fall   = toggle && level_q;
  end

  // Debounce counter, clean level and edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt_q <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
    end else begin
      if ((sync_s == level_q) || toggle) begin
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + DebW'(1);
      end
      level_q <= level_q ^ toggle;
      press_q <= rise;
      rel_q   <= fall;
    end
  end

  // Auto-repeat FSM; a release always wins over a due step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rep_cnt_q <= '0;
      step_q    <= 1'b0;
    end else begin
      step_q <= 1'b0;
      if (fall) begin
        state_q   <= StIdle;
        rep_cnt_q <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (rise) begin
              state_q   <= StDelay;
              rep_cnt_q <= '0;
              step_q    <= 1'b1;
            end
          end
          StDelay: begin
            if (rep_cnt_q == DelayLast) begin
              step_q    <= 1'b1;
              rep_cnt_q <= '0;
              state_q   <= (REPEAT_PERIOD == 0) ? StHold : StRepeat;
            end else begin
              rep_cnt_q <= rep_cnt_q + RepW'(1);
            end
          end
          StRepeat: begin
            if (rep_cnt_q == PeriodLast) begin
              step_q    <= 1'b1;
              rep_cnt_q <= '0;
            end else begin
              rep_cnt_q <= rep_cnt_q + RepW'(1);
            end
          end
          StHold: begin
            rep_cnt_q <= '0;
          end
          default: begin
            state_q   <= StIdle;
            rep_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign level = level_q;
  assign press = press_q;
  assign rel   = rel_q;
  assign step  = step_q;

endmodule

// File: rtl/btn_conditioner.sv
// N independent button channels for the pong top level.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned N_CH            = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int unsigned REPEAT_DELAY    = REPEAT_250MS,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_50MS
) (
  input logic               clk,
  input logic               rst,
  btn_conditioner_if.slave  bus
);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    btn_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .btn_in (bus.btn_in[i]),
      .level  (bus.level[i]),
      .press  (bus.press[i]),
      .rel    (bus.rel[i]),
      .step   (bus.step[i])
    );
  end

endmodule
